// File: rtl/irq_mask_ctrl_pkg.sv
// Shared constants for the legacy-IRQ mask controller: register map, CTRL
// field positions and FSM state encoding.
package irq_mask_ctrl_pkg;

   localparam logic [1:0] ADDR_PENDING = 2'd0;
   localparam logic [1:0] ADDR_MASK    = 2'd1;
   localparam logic [1:0] ADDR_CTRL    = 2'd2;
   localparam logic [1:0] ADDR_RAW     = 2'd3;

   localparam int CTRL_GEN_BIT  = 0;
   localparam int CTRL_HOLD_LSB = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_HOLDOFF = 2'd2
   } state_t;

endpackage

// File: rtl/irq_mask_ctrl_sync_edge_det.sv
// Two-flop synchroniser per bit followed by a rising-edge detector.
// level is the synchronised input; pulse is high for one clock per rising edge.
module sync_edge_det #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [W-1:0] din,
   output logic [W-1:0] level,
   output logic [W-1:0] pulse
);

   logic [W-1:0] meta;
   logic [W-1:0] sync;
   logic [W-1:0] prev;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta <= '0;
         sync <= '0;
         prev <= '0;
      end else begin
         meta <= din;
         sync <= meta;
         prev <= sync;
      end
   end

   assign level = sync;
   assign pulse = sync & ~prev;

endmodule

// File: rtl/irq_mask_ctrl.sv
// Sticky, maskable interrupt aggregator driving one level IRQ towards the PCIe
// core, with a programmable hold-off gap between successive assertions.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | irq low, waiting for an enabled pending source
// ST_ASSERT  | irq high while any enabled pending source remains
// ST_HOLDOFF | irq low, counting down the HOLD value captured on entry
module irq_mask_ctrl
   import irq_mask_ctrl_pkg::*;
#(
   parameter int B      = 32,
   parameter int NSRC   = 8,
   parameter int HOLD_W = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            write_n,
   input  logic [1:0]      address,
   input  logic [B-1:0]    writedata,
   output logic [B-1:0]    readdata,
   input  logic [NSRC-1:0] irq_src,
   output logic            irq
);

   logic [NSRC-1:0]   src_level;
   logic [NSRC-1:0]   src_pulse;
   logic [NSRC-1:0]   pending;
   logic [NSRC-1:0]   mask;
   logic              gen;
   logic [HOLD_W-1:0] hold;
   logic [HOLD_W-1:0] cnt;
   logic [NSRC-1:0]   w1c;
   logic              wr_en;
   logic              act;
   state_t            state;
   logic              unused_wd;

   sync_edge_det #(.W(NSRC)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (irq_src),
      .level   (src_level),
      .pulse   (src_pulse)
   );

   assign wr_en     = ~write_n;
   assign w1c       = (wr_en && address == ADDR_PENDING) ? writedata[NSRC-1:0] : '0;
   assign act       = gen & (|(pending & mask));
   assign unused_wd = ^writedata;

   // A new edge in the same cycle as a W1C on that bit keeps the bit set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending <= '0;
         mask    <= '0;
         gen     <= 1'b0;
         hold    <= '0;
      end else begin
         pending <= (pending & ~w1c) | src_pulse;
         if (wr_en && address == ADDR_MASK) begin
            mask <= writedata[NSRC-1:0];
         end
         if (wr_en && address == ADDR_CTRL) begin
            gen  <= writedata[CTRL_GEN_BIT];
            hold <= writedata[CTRL_HOLD_LSB +: HOLD_W];
         end
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_PENDING: readdata[NSRC-1:0] = pending;
         ADDR_MASK:    readdata[NSRC-1:0] = mask;
         ADDR_CTRL: begin
            readdata[CTRL_GEN_BIT]             = gen;
            readdata[CTRL_HOLD_LSB +: HOLD_W]  = hold;
         end
         default:      readdata[NSRC-1:0] = src_level;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         irq   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (act) begin
                  state <= ST_ASSERT;
                  irq   <= 1'b1;
               end
            end
            ST_ASSERT: begin
               if (!act) begin
                  irq <= 1'b0;
                  if (hold == '0) begin
                     state <= ST_IDLE;
                  end else begin
                     cnt   <= hold;
                     state <= ST_HOLDOFF;
                  end
               end
            end
            ST_HOLDOFF: begin
               cnt <= cnt - HOLD_W'(1);
               if (cnt == HOLD_W'(1)) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
               irq   <= 1'b0;
            end
         endcase
      end
   end

endmodule
